// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: IDLE/START/DATA/PARITY/STOP sequencing.
// Define UART_RX_ERR_STATUS_EN to expose par_err_flag/stp_err_flag.
module uart_rx_ctrl #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      dat_samp_en,
  output logic                      strt_chk_en,
  output logic                      deser_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      data_valid,
`ifdef UART_RX_ERR_STATUS_EN
  output logic                      par_err_flag,
  output logic                      stp_err_flag,
`endif
  output logic                      busy
);

  localparam int W = PRESCALE_WIDTH;
  localparam logic [W-1:0] P_MIN = W'(8);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t         state;
  state_t         nxt_state;
  logic [W-1:0]   p_r;
  logic [W-1:0]   nxt_p;
  logic [W-1:0]   nxt_edge;
  logic [W-1:0]   chk_pt;
  logic [W-1:0]   nxt_chk;
  logic [3:0]     nxt_bit;
  logic           bit_end;
  logic           at_chk;
  logic           nxt_dv;
  logic           start_ent;
  logic           glitch_f;
  logic           par_f;
  logic           stp_f;

  assign chk_pt    = (p_r >> 1) + TWO;
  assign nxt_chk   = (nxt_p >> 1) + TWO;
  assign bit_end   = (edge_cnt == p_r - ONE);
  assign at_chk    = (edge_cnt == chk_pt);
  assign start_ent = (state == IDLE) && (nxt_state == START);

`ifdef UART_RX_ERR_STATUS_EN
  assign par_err_flag = par_f;
  assign stp_err_flag = stp_f;
`endif

  always_comb begin
    nxt_state = state;
    nxt_edge  = '0;
    nxt_bit   = bit_cnt;
    nxt_p     = p_r;
    nxt_dv    = 1'b0;
    if (state != IDLE)
      nxt_edge = bit_end ? '0 : edge_cnt + ONE;
    unique case (state)
      IDLE: begin
        nxt_bit = '0;
        if (!RX_IN) begin
          nxt_state = START;
          nxt_p     = (Prescale < P_MIN) ? P_MIN : Prescale;
        end
      end
      START: begin
        if (bit_end) begin
          nxt_state = glitch_f ? IDLE : DATA;
          nxt_bit   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 4'd7) begin
            nxt_bit   = '0;
            nxt_state = PAR_EN ? PARITY : STOP;
          end else begin
            nxt_bit = bit_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end)
          nxt_state = STOP;
      end
      STOP: begin
        if (bit_end) begin
          nxt_state = IDLE;
          nxt_dv    = !par_f && !stp_f;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Strobes are registered from next-state values so they line up with edge_cnt
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      p_r         <= P_MIN;
      glitch_f    <= 1'b0;
      par_f       <= 1'b0;
      stp_f       <= 1'b0;
      busy        <= 1'b0;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      state       <= nxt_state;
      edge_cnt    <= nxt_edge;
      bit_cnt     <= nxt_bit;
      p_r         <= nxt_p;
      busy        <= (nxt_state != IDLE);
      dat_samp_en <= (nxt_state != IDLE);
      strt_chk_en <= (nxt_state == START) && (nxt_edge == nxt_chk);
      deser_en    <= (nxt_state == DATA) && (nxt_edge == nxt_chk);
      par_chk_en  <= (nxt_state == PARITY) && (nxt_edge == nxt_chk);
      stp_chk_en  <= (nxt_state == STOP) && (nxt_edge == nxt_chk);
      data_valid  <= nxt_dv;
      if (start_ent) begin
        glitch_f <= 1'b0;
        par_f    <= 1'b0;
        stp_f    <= 1'b0;
      end else begin
        if (state == START && at_chk)
          glitch_f <= strt_glitch;
        if (state == PARITY && at_chk && par_err)
          par_f <= 1'b1;
        if (state == STOP && at_chk && stp_err)
          stp_f <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE_WIDTH, default 6, giving the width of Prescale and edge_cnt.
REQ-002 SHALL have the following ports, one per line:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- RX_IN  in  1  serial line, idle high.
- PAR_EN  in  1  parity bit present.
- Prescale  in  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32.
- strt_glitch  in  1  start checker result.
- par_err  in  1  parity checker result.
- stp_err  in  1  stop checker result.
- edge_cnt  out  PRESCALE_WIDTH  oversample index within the current bit, driven to the data sampler.
- bit_cnt  out  4  data bit index, 0..7.
- dat_samp_en  out  1  sampler enable.
- strt_chk_en, deser_en, par_chk_en, stp_chk_en  out  1 each  one-cycle strobes.
- data_valid  out  1  one-cycle frame-good pulse.
- busy  out  1  frame in progress.

Function
REQ-003 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-004 SHALL transition from IDLE to START in the cycle after RX_IN is sampled 0; edge_cnt = 0 in the first START cycle.
REQ-005 SHALL latch Prescale into P on the IDLE->START transition, with values below 8 clamped to 8; Prescale changes mid-frame SHALL be ignored.
REQ-006 SHALL increment edge_cnt every cycle outside IDLE, wrapping from P-1 to 0; "bit end" = edge_cnt == P-1.
REQ-007 SHALL define check point C = (P>>1)+2 (P=8 gives 6, P=16 gives 10, P=32 gives 18) and assert the state's strobe only in the cycle with edge_cnt == C.
REQ-008 SHALL map strobes to states as follows: START gives strt_chk_en, DATA gives deser_en, PARITY gives par_chk_en, STOP gives stp_chk_en.
REQ-009 SHALL, in START at bit end, go to IDLE if strt_glitch was sampled 1 at C, else go to DATA with bit_cnt = 0.
REQ-010 SHALL, in DATA at bit end, increment bit_cnt; at bit_cnt == 7 it SHALL go to PARITY if PAR_EN, else to STOP.
REQ-011 SHALL sample PAR_EN on the DATA exit decision.
REQ-012 SHALL latch par_err at C in PARITY into a frame flag; PARITY at bit end SHALL go to STOP.
REQ-013 SHALL, in STOP at bit end, go to IDLE and pulse data_valid for exactly 1 cycle in that transition cycle, only if the parity flag is clear and stp_err was 0 at C.
REQ-014 SHALL clear the frame error flags on entry to START.
REQ-015 SHALL assert dat_samp_en and busy in every state except IDLE.
REQ-016 SHALL support back-to-back frames: RX_IN low in the first IDLE cycle after STOP SHALL start a new frame, with no additional gap required.
REQ-017 SHALL hold edge_cnt and bit_cnt at 0 in IDLE.
REQ-018 SHALL ignore RX_IN in all states other than IDLE; the checker inputs carry the line information.

Reset
REQ-019 SHALL, on RST low, asynchronously force IDLE with edge_cnt = 0, bit_cnt = 0, P = 8, all flags cleared and all outputs 0.
REQ-020 SHALL abandon the current frame on reset mid-frame, with no data_valid pulse.
REQ-021 SHALL require the line to be sampled low in IDLE after reset release before a new frame starts.

Configuration
REQ-022 SHALL, with macro UART_RX_ERR_STATUS_EN defined, add outputs par_err_flag and stp_err_flag; each is set at the corresponding check point on error, held through IDLE, and cleared on entry to START.
REQ-023 SHALL, without UART_RX_ERR_STATUS_EN, omit these ports and flags; the internal parity frame flag is still present, and all other behaviour is identical.

Verification
REQ-024 SHALL cover: P=8, PAR_EN=0, byte 0xA5, clean checkers -> 8 deser_en strobes at edge_cnt 6, data_valid pulse 80 cycles after START entry, busy then 0.
REQ-025 SHALL cover: P=16, PAR_EN=1, par_err=1 at the PARITY check point -> no data_valid; par_err_flag=1 when the macro is defined.
REQ-026 SHALL cover: P=8, strt_glitch=1 at edge_cnt 6 of START -> IDLE after edge_cnt 7, no deser_en, bit_cnt stays 0.
REQ-027 SHALL cover: P=32, Prescale changed to 8 during DATA -> frame still runs at 32 edges per bit, strobes at edge_cnt 18.
REQ-028 SHALL cover: RST asserted at bit_cnt=4 of DATA -> all outputs 0 immediately; a new frame later completes with data_valid.
REQ-029 SHALL cover: two back-to-back frames with P=8, PAR_EN=0 -> two data_valid pulses 81 cycles apart.
